coco_ioctl_upload: RTL
======================

// Module: coco_ioctl_upload
// PURPOSE
//  Core-to-HPS side of the ioctl file channel: serves ioctl_din to hps_io during an upload so the
//  OSD can save a RAM snapshot. Emits an 8-byte header, then CoCo RAM bytes.
//  Halts the CPU with halt_req/halt_ack and fetches each byte over a req/ack memory port.
//  Sits in the emu top beside hps_io; the memory port is arbitrated into the po8 RAM path.
// PARAMETERS
//  MEM_BYTES   32768   RAM bytes dumped after header; must be a power of 2, <= 65528
//  MEM_BASE    16'h0000 CPU address of dumped byte 0
//  TIMEOUT     1023    max cycles in S_MEM waiting for mem_ack
// PORTS
//  clk_sys        in   1   system clock, single clock domain
//  reset          in   1   synchronous, active-high reset
//  ioctl_upload   in   1   high for whole upload transfer (from hps_io)
//  ioctl_rd       in   1   one-cycle read strobe (from hps_io)
//  ioctl_addr     in   16  byte offset in file, valid with ioctl_rd
//  ioctl_din      out  8   byte returned to hps_io
//  ioctl_wait     out  1   stall to hps_io; high while a memory byte is being fetched
//  flags          in   8   copied into header byte 5 (bit0 = artifact phase)
//  halt_req       out  1   request CPU halt for the duration of the upload
//  halt_ack       in   1   CPU halted, RAM bus free
//  mem_req        out  1   memory read request, held until mem_ack or timeout
//  mem_addr       out  16  CPU address of the requested byte
//  mem_ack        in   1   one-cycle pulse; mem_dout valid in the same cycle
//  mem_dout       in   8   memory read data
//  busy           out  1   FSM not in S_IDLE
//  err            out  1   sticky error: timeout or protocol violation; cleared at next upload start
// BEHAVIOUR
//  Reset values: ioctl_din=8'hFF, ioctl_wait=0, halt_req=0, mem_req=0, mem_addr=0, busy=0, err=0.
//  Reset mid-operation aborts immediately, drops mem_req and halt_req the next cycle, and returns to S_IDLE.
//  File layout (offsets):
//   - 0..3 = 43 43 32 53 ("CC2S"); 4 = 8'h01 (version); 5 = flags; 6..7 = MEM_BYTES, big-endian.
//   - 8..8+MEM_BYTES-1 = RAM at MEM_BASE+(addr-8), 16-bit wrap.
//   - Any offset >= 8+MEM_BYTES reads 8'hFF and issues no memory request.
//  Halt handshake:
//   - Rising edge of ioctl_upload sets halt_req and clears err.
//   - halt_req clears on the first cycle where ioctl_upload=0 and FSM is in S_IDLE.
//  FSM states: S_IDLE, S_HALT, S_MEM.
//   - S_IDLE, ioctl_rd to a header or out-of-range offset: ioctl_din updates at the next edge
//     (latency 1). ioctl_wait stays 0 and the state stays S_IDLE.
//   - S_IDLE, ioctl_rd to a RAM offset: at the next edge, ioctl_wait=1 and mem_addr is latched.
//     Go to S_MEM if halt_ack=1, otherwise go to S_HALT.
//   - S_HALT -> S_MEM on the first cycle halt_ack=1. No timeout in this state.
//   - S_MEM: mem_req=1 and a timeout counter runs.
//     - On mem_ack: ioctl_din<=mem_dout, mem_req<=0, ioctl_wait<=0, go to S_IDLE
//       (ioctl_wait low the cycle after mem_ack).
//     - If the counter reaches TIMEOUT first: ioctl_din<=8'hEE, err<=1, drop mem_req and ioctl_wait,
//       go to S_IDLE.
//   - ioctl_rd while busy: ignored, err<=1.
//   - ioctl_upload falling while busy: the current access completes normally, then halt_req drops.
//  Width rules: offset compare in 17 bits; (addr-8)+MEM_BASE truncated to 16 bits.
//  mem_ack outside S_MEM is ignored.
// STRUCTURE
//  Package coco_upload_pkg holds:
//   - typedef enum logic [1:0] {S_IDLE,S_HALT,S_MEM} upl_state_t
//   - HDR_LEN=8, MAGIC bytes, VERSION=8'h01, ERR_BYTE=8'hEE, PAD_BYTE=8'hFF
//   - function hdr_byte(idx, flags, len)
//  Single module; no sub-module. The timeout counter is 10 bits, clog2(TIMEOUT+1).
// TESTING
//  1. Upload start, ioctl_rd at offsets 0..7 with flags=8'h01 -> din 43,43,32,53,01,01,80,00 one cycle
//     after each strobe; ioctl_wait never 1.
//  2. halt_ack=1, mem model with 3-cycle ack, read offset 8 (RAM[0000]=8'hA5) -> ioctl_wait=1 for 4 cycles,
//     mem_addr=0000, din=A5.
//  3. halt_ack held 0 for 20 cycles, read offset 8+16'h7FFF -> S_HALT, no mem_req until halt_ack,
//     then mem_addr=7FFF.
//  4. mem_ack never arrives -> after 1023 cycles din=EE, err=1, wait=0, mem_req=0;
//     the next upload start clears err.
//  5. Read offset 8+MEM_BYTES (16'h8008) -> din=FF, no mem_req. ioctl_rd during S_MEM -> ignored, err=1.
//  6. Assert reset during S_MEM -> next cycle mem_req=0, halt_req=0, ioctl_wait=0, din=FF, busy=0.

Source files
------------

// File: rtl/coco_ioctl_upload_pkg.sv
`default_nettype none
// ============================================================================
// Package     : coco_upload_pkg
// Description : Shared types and constants for the CoCo ioctl snapshot upload
//               channel. Holds the FSM state type, the file header layout
//               constants and the header byte generator.
// Revision    : 1.0  initial release
// ============================================================================
package coco_upload_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HALT = 2'd1,
    S_MEM  = 2'd2
  } upl_state_t;

  localparam int          HDR_LEN  = 8;
  localparam logic [31:0] MAGIC    = 32'h4343_3253;  // "CC2S"
  localparam logic [7:0]  VERSION  = 8'h01;
  localparam logic [7:0]  ERR_BYTE = 8'hEE;
  localparam logic [7:0]  PAD_BYTE = 8'hFF;

  // Header byte at file offset idx (0..7). The RAM length is stored big-endian.
  function automatic logic [7:0] hdr_byte(input logic [2:0]  idx,
                                          input logic [7:0]  flags,
                                          input logic [15:0] len);
    logic [7:0] b;
    b = PAD_BYTE;
    case (idx)
      3'd0: b = MAGIC[31:24];
      3'd1: b = MAGIC[23:16];
      3'd2: b = MAGIC[15:8];
      3'd3: b = MAGIC[7:0];
      3'd4: b = VERSION;
      3'd5: b = flags;
      3'd6: b = len[15:8];
      3'd7: b = len[7:0];
      default: b = PAD_BYTE;
    endcase
    return b;
  endfunction

endpackage
`default_nettype wire

// File: rtl/coco_ioctl_upload_if.sv
`default_nettype none
// ============================================================================
// Interface   : coco_ioctl_upload_if
// Description : Bundles the hps_io ioctl upload signals, the CPU halt
//               handshake, the RAM read port and the status outputs of the
//               snapshot upload block.
//   slave  modport : the upload block itself (serves ioctl reads, issues
//                    halt and memory requests)
//   master modport : the surrounding system (hps_io, CPU, RAM arbiter)
// Revision    : 1.0  initial release
// ============================================================================
interface coco_ioctl_upload_if;

  // hps_io ioctl side
  logic        ioctl_upload;  // high for the whole upload transfer
  logic        ioctl_rd;      // one-cycle read strobe
  logic [15:0] ioctl_addr;    // file byte offset, valid with ioctl_rd
  logic [7:0]  ioctl_din;     // byte returned to hps_io
  logic        ioctl_wait;    // stall while a RAM byte is fetched
  logic [7:0]  flags;         // copied into header byte 5

  // CPU halt handshake
  logic        halt_req;
  logic        halt_ack;

  // RAM read port
  logic        mem_req;
  logic [15:0] mem_addr;
  logic        mem_ack;
  logic [7:0]  mem_dout;

  // status
  logic        busy;
  logic        err;

  modport slave (
    input  ioctl_upload, ioctl_rd, ioctl_addr, flags, halt_ack, mem_ack, mem_dout,
    output ioctl_din, ioctl_wait, halt_req, mem_req, mem_addr, busy, err
  );

  modport master (
    output ioctl_upload, ioctl_rd, ioctl_addr, flags, halt_ack, mem_ack, mem_dout,
    input  ioctl_din, ioctl_wait, halt_req, mem_req, mem_addr, busy, err
  );

endinterface
`default_nettype wire

// File: rtl/coco_ioctl_upload.sv
`default_nettype none
// ============================================================================
// Module      : coco_ioctl_upload
// Description : Serves ioctl_din to hps_io during an upload so the OSD can
//               save a CoCo RAM snapshot: an 8-byte header followed by
//               MEM_BYTES of RAM starting at MEM_BASE. The CPU is halted for
//               the whole upload and every RAM byte is fetched over a
//               req/ack port guarded by a timeout.
// Ports       :
//   clk_sys : system clock
//   reset   : synchronous active-high reset
//   bus     : coco_ioctl_upload_if.slave (ioctl, halt, memory, status)
// Parameters  :
//   MEM_BYTES : RAM bytes dumped after the header (power of 2, <= 65528)
//   MEM_BASE  : CPU address of dumped byte 0
//   TIMEOUT   : maximum cycles in S_MEM waiting for mem_ack
// Revision    : 1.0  initial release
// ============================================================================
module coco_ioctl_upload
  import coco_upload_pkg::*;
#(
  parameter int          MEM_BYTES = 32768,
  parameter logic [15:0] MEM_BASE  = 16'h0000,
  parameter int          TIMEOUT   = 1023
) (
  input  wire                   clk_sys,
  input  wire                   reset,
  coco_ioctl_upload_if.slave    bus
);

  localparam int          c_TMO_W   = $clog2(TIMEOUT + 1);
  localparam logic [16:0] c_HDR_END = 17'(HDR_LEN);
  localparam logic [16:0] c_RAM_END = 17'(HDR_LEN + MEM_BYTES);
  localparam logic [15:0] c_LEN     = 16'(MEM_BYTES);
  localparam logic [c_TMO_W-1:0] c_TMO_LAST = c_TMO_W'(TIMEOUT - 1);

  upl_state_t         r_state;
  logic               r_upload_d;
  logic [7:0]         r_din;
  logic               r_wait;
  logic               r_halt_req;
  logic               r_mem_req;
  logic [15:0]        r_mem_addr;
  logic               r_err;
  logic [c_TMO_W-1:0] r_tmo;

  logic [16:0] w_off;
  logic        w_is_hdr;
  logic        w_is_pad;
  logic [15:0] w_ram_addr;
  logic        w_up_rise;

  // Offsets are compared in 17 bits so HDR_LEN + MEM_BYTES never wraps.
  assign w_off      = {1'b0, bus.ioctl_addr};
  assign w_is_hdr   = (w_off < c_HDR_END);
  assign w_is_pad   = (w_off >= c_RAM_END);
  assign w_ram_addr = bus.ioctl_addr - 16'(HDR_LEN) + MEM_BASE;
  assign w_up_rise  = bus.ioctl_upload & ~r_upload_d;

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_upload_d <= 1'b0;
      r_din      <= PAD_BYTE;
      r_wait     <= 1'b0;
      r_halt_req <= 1'b0;
      r_mem_req  <= 1'b0;
      r_mem_addr <= 16'h0000;
      r_err      <= 1'b0;
      r_tmo      <= '0;
    end else begin
      r_upload_d <= bus.ioctl_upload;

      // The halt request is held until the transfer has ended and any
      // in-flight RAM access has finished, so the CPU never resumes mid-read.
      if (w_up_rise) begin
        r_halt_req <= 1'b1;
        r_err      <= 1'b0;
      end else if (!bus.ioctl_upload && r_state == S_IDLE) begin
        r_halt_req <= 1'b0;
      end

      case (r_state)
        S_IDLE: begin
          if (bus.ioctl_rd) begin
            if (w_is_hdr) begin
              r_din <= hdr_byte(bus.ioctl_addr[2:0], bus.flags, c_LEN);
            end else if (w_is_pad) begin
              r_din <= PAD_BYTE;
            end else begin
              r_wait     <= 1'b1;
              r_mem_addr <= w_ram_addr;
              r_tmo      <= '0;
              if (bus.halt_ack) begin
                r_state   <= S_MEM;
                r_mem_req <= 1'b1;
              end else begin
                r_state <= S_HALT;
              end
            end
          end
        end

        S_HALT: begin
          if (bus.ioctl_rd) begin
            r_err <= 1'b1;
          end
          if (bus.halt_ack) begin
            r_state   <= S_MEM;
            r_mem_req <= 1'b1;
            r_tmo     <= '0;
          end
        end

        S_MEM: begin
          if (bus.ioctl_rd) begin
            r_err <= 1'b1;
          end
          if (bus.mem_ack) begin
            r_din     <= bus.mem_dout;
            r_mem_req <= 1'b0;
            r_wait    <= 1'b0;
            r_state   <= S_IDLE;
          end else if (r_tmo == c_TMO_LAST) begin
            // The hps side still gets a byte so the transfer can proceed;
            // the marker value plus the sticky err flag flag the bad dump.
            r_din     <= ERR_BYTE;
            r_err     <= 1'b1;
            r_mem_req <= 1'b0;
            r_wait    <= 1'b0;
            r_state   <= S_IDLE;
          end else begin
            r_tmo <= r_tmo + 1'b1;
          end
        end

        default: begin
          r_state   <= S_IDLE;
          r_mem_req <= 1'b0;
          r_wait    <= 1'b0;
        end
      endcase
    end
  end

  assign bus.ioctl_din  = r_din;
  assign bus.ioctl_wait = r_wait;
  assign bus.halt_req   = r_halt_req;
  assign bus.mem_req    = r_mem_req;
  assign bus.mem_addr   = r_mem_addr;
  assign bus.busy       = (r_state != S_IDLE);
  assign bus.err        = r_err;

endmodule
`default_nettype wire
